fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding/hazard successor to the fixed two-source forwarder in the Starfish pipeline. Tracks in-flight register writers in an internal shadow pipeline of NUM_FWD_STAGES entries and drives rs1/rs2 operand-source selects for the instruction leaving decode. Generates load-use stall and bubble insertion. Honours branch flush from EX. Sits beside DE_block; selects feed the EX operand muxes, stall gates pcWrite and the IF/DE register load enables.

Parameters:
NUM_FWD_STAGES, 2, in-flight stages tracked after decode (EX, MEM, ... ); legal 1..6
REG_ADDR_W, 5, register address width
LOAD_LAT, 1, entries a load must advance past before its data is forwardable; legal 0..NUM_FWD_STAGES-1
SEL_W, $clog2(NUM_FWD_STAGES+1), select width (derived; not overridden)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
de_valid  in  1  decode holds a real instruction
de_rs1  in  REG_ADDR_W  source 1 address
de_rs2  in  REG_ADDR_W  source 2 address
de_uses_rs1  in  1  instruction reads rs1
de_uses_rs2  in  1  instruction reads rs2
de_rd  in  REG_ADDR_W  destination address
de_reg_write  in  1  instruction writes rd
de_is_load  in  1  instruction is a load
flush  in  1  branch taken in EX; squash decode and EX-entry
rs1_sel  out  SEL_W  0 = register file, k = forward from stage k (1 = youngest)
rs2_sel  out  SEL_W  as rs1_sel
stall  out  1  hold PC and IF/DE registers, bubble into EX
stall_count  out  32  stall cycle counter (present only with FWD_STALL_CNT_EN)

Behaviour:
- Reset: interface is one clock (clk) with asynchronous active-high reset (reset). Asserting reset clears every entry valid bit immediately, independent of clk. With all entries invalid, rs1_sel=0, rs2_sel=0, stall=0; stall_count=0.
- State: entry[i], i=0..NUM_FWD_STAGES-1, each {valid, rd, is_load}. entry[0] = instruction in EX.
- Each rising edge, all entries shift: entry[i+1] <= entry[i]; top entry drops out.
- entry[0] is loaded as follows, in priority order:
  - flush=1: entry[0] <= invalid. Flush overrides stall.
  - stall=1: entry[0] <= invalid (bubble).
  - Otherwise: entry[0] <= {de_valid & de_reg_write & (de_rd!=0), de_rd, de_is_load}.
- Match on rsN: the smallest i with entry[i].valid and entry[i].rd==de_rsN; no match when de_rsN==0 or de_usesN==0.
- Selects (combinational from state and decode inputs, zero-latency): rsN_sel = i+1 on a match, else 0.
  - Youngest writer always wins when several entries share rd.
  - Entries at i >= NUM_FWD_STAGES never exist; writeback is assumed visible through the register file (write-before-read).
- Stall (combinational): stall=1 iff de_valid & ~flush & (rs1 or rs2 match at index i with entry[i].is_load & i < LOAD_LAT).
  - While stalled, the load advances, so the stall self-clears after LOAD_LAT-i cycles.
  - When stall=1, the sel outputs are don't-care; the bench checks them only when stall=0.
- Flush: clears only entry[0]; older entries keep shifting and forwarding. stall is forced 0 in a flush cycle.
- Reset asserted mid-stall: stall drops asynchronously with the entries; the first edge after release loads entry[0] normally.

Optional Feature:
FWD_STALL_CNT_EN
- Defined: stall_count port exists. Counts clk edges with stall=1 & ~reset, saturates at 32'hFFFF_FFFF, and is cleared by reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Back-to-back ALU dependency: addi x5 (rd=5, write) then add rs1=5 next cycle -> rs1_sel=1, stall=0. With one independent instruction between them -> rs1_sel=2.
- Load-use, LOAD_LAT=1: lw x6 then add rs2=6 -> stall=1 for exactly 1 cycle, then rs2_sel=2. With FWD_STALL_CNT_EN, stall_count goes 0->1.
- Duplicate writers: addi x7 then addi x7 then use rs1=7 -> rs1_sel=1 (youngest). Same sequence with rd=x0 -> rs1_sel=0.
- Flush: flush=1 while the writer of x8 is in decode, then read x8 -> rs1_sel=0, stall=0. Flush asserted during a load-use stall -> stall=0 that cycle.
- Asynchronous reset: assert reset between edges while entries are valid and stall=1 -> stall=0 and sels=0 before the next edge. stall_count=0.
- Parameter sweep: NUM_FWD_STAGES=4, LOAD_LAT=2, use three instructions after the writer -> rs1_sel=4. Load followed immediately by a use -> 2 stall cycles.

Source files
------------

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle for fwd_hazard_unit: decode operand info in, forwarding selects and stall out.
// stall_count exists only when FWD_STALL_CNT_EN is defined.
interface fwd_hazard_unit_if #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_ADDR_W     = 5,
    localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
);
    logic                  de_valid;
    logic [REG_ADDR_W-1:0] de_rs1;
    logic [REG_ADDR_W-1:0] de_rs2;
    logic                  de_uses_rs1;
    logic                  de_uses_rs2;
    logic [REG_ADDR_W-1:0] de_rd;
    logic                  de_reg_write;
    logic                  de_is_load;
    logic                  flush;
    logic [SEL_W-1:0]      rs1_sel;
    logic [SEL_W-1:0]      rs2_sel;
    logic                  stall;
`ifdef FWD_STALL_CNT_EN
    logic [31:0]           stall_count;
`endif

    modport master (
        output de_valid, de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
        output de_rd, de_reg_write, de_is_load, flush,
`ifdef FWD_STALL_CNT_EN
        input  stall_count,
`endif
        input  rs1_sel, rs2_sel, stall
    );

    modport slave (
        input  de_valid, de_rs1, de_rs2, de_uses_rs1, de_uses_rs2,
        input  de_rd, de_reg_write, de_is_load, flush,
`ifdef FWD_STALL_CNT_EN
        output stall_count,
`endif
        output rs1_sel, rs2_sel, stall
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select / load-use stall unit tracking NUM_FWD_STAGES in-flight writers after decode.
// Define FWD_STALL_CNT_EN to add the saturating stall_count output.
module fwd_hazard_unit #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int LOAD_LAT       = 1,
    localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
    input logic              clk,
    input logic              reset,
    fwd_hazard_unit_if.slave bus
);

    // Shadow pipeline: index 0 is the instruction currently in EX.
    logic [NUM_FWD_STAGES-1:0] ent_valid;
    logic [NUM_FWD_STAGES-1:0] ent_load;
    logic [REG_ADDR_W-1:0]     ent_rd [NUM_FWD_STAGES];

    logic [SEL_W-1:0] rs1_sel;
    logic [SEL_W-1:0] rs2_sel;
    logic             rs1_haz;
    logic             rs2_haz;
    logic             stall;

    // Scan oldest to youngest so the youngest matching writer is the one left standing.
    always_comb begin
        rs1_sel = '0;
        rs2_sel = '0;
        rs1_haz = 1'b0;
        rs2_haz = 1'b0;
        for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
            if (bus.de_uses_rs1 && (bus.de_rs1 != '0) && ent_valid[i] &&
                (ent_rd[i] == bus.de_rs1)) begin
                rs1_sel = SEL_W'(i + 1);
                rs1_haz = ent_load[i] && (i < LOAD_LAT);
            end
            if (bus.de_uses_rs2 && (bus.de_rs2 != '0) && ent_valid[i] &&
                (ent_rd[i] == bus.de_rs2)) begin
                rs2_sel = SEL_W'(i + 1);
                rs2_haz = ent_load[i] && (i < LOAD_LAT);
            end
        end
        stall = bus.de_valid && !bus.flush && (rs1_haz || rs2_haz);
    end

    assign bus.rs1_sel = rs1_sel;
    assign bus.rs2_sel = rs2_sel;
    assign bus.stall   = stall;

    // A flushed or stalled decode slot enters EX as a bubble; everything older keeps moving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int i = 0; i < NUM_FWD_STAGES; i++) begin
                ent_rd[i] <= '0;
            end
        end else begin
            for (int i = NUM_FWD_STAGES - 1; i > 0; i--) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_load[i]  <= ent_load[i-1];
                ent_rd[i]    <= ent_rd[i-1];
            end
            ent_valid[0] <= !bus.flush && !stall && bus.de_valid &&
                            bus.de_reg_write && (bus.de_rd != '0);
            ent_load[0]  <= bus.de_is_load;
            ent_rd[0]    <= bus.de_rd;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance (2 stages, LOAD_LAT=1) and a 4-stage, LOAD_LAT=2 instance.
module tb_fwd_hazard_unit;

    logic clk;
    logic reset;

    logic       de_valid;
    logic [4:0] de_rs1;
    logic [4:0] de_rs2;
    logic       de_uses_rs1;
    logic       de_uses_rs2;
    logic [4:0] de_rd;
    logic       de_reg_write;
    logic       de_is_load;
    logic       flush;

    int tests_run;
    int tests_failed;

    fwd_hazard_unit_if #(.NUM_FWD_STAGES(2), .REG_ADDR_W(5)) bus1 ();
    fwd_hazard_unit_if #(.NUM_FWD_STAGES(4), .REG_ADDR_W(5)) bus2 ();

    // Both instances see the same decode stream; each phase checks one of them.
    assign bus1.de_valid     = de_valid;
    assign bus1.de_rs1       = de_rs1;
    assign bus1.de_rs2       = de_rs2;
    assign bus1.de_uses_rs1  = de_uses_rs1;
    assign bus1.de_uses_rs2  = de_uses_rs2;
    assign bus1.de_rd        = de_rd;
    assign bus1.de_reg_write = de_reg_write;
    assign bus1.de_is_load   = de_is_load;
    assign bus1.flush        = flush;
    assign bus2.de_valid     = de_valid;
    assign bus2.de_rs1       = de_rs1;
    assign bus2.de_rs2       = de_rs2;
    assign bus2.de_uses_rs1  = de_uses_rs1;
    assign bus2.de_uses_rs2  = de_uses_rs2;
    assign bus2.de_rd        = de_rd;
    assign bus2.de_reg_write = de_reg_write;
    assign bus2.de_is_load   = de_is_load;
    assign bus2.flush        = flush;

    fwd_hazard_unit #(.NUM_FWD_STAGES(2), .REG_ADDR_W(5), .LOAD_LAT(1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    fwd_hazard_unit #(.NUM_FWD_STAGES(4), .REG_ADDR_W(5), .LOAD_LAT(2)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       de_valid;
        logic [4:0] rs1;
        logic       uses1;
        logic [4:0] rs2;
        logic       uses2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       fl;
        int         exp_rs1;
        int         exp_rs2;
        logic       exp_stall;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    function automatic vec_t mk(input logic v, input int rs1, input logic u1, input int rs2,
                                input logic u2, input int rd, input logic wr, input logic ld,
                                input logic fl, input int e1, input int e2, input logic es);
        vec_t r;
        r.de_valid  = v;
        r.rs1       = 5'(rs1);
        r.uses1     = u1;
        r.rs2       = 5'(rs2);
        r.uses2     = u2;
        r.rd        = 5'(rd);
        r.wr        = wr;
        r.ld        = ld;
        r.fl        = fl;
        r.exp_rs1   = e1;
        r.exp_rs2   = e2;
        r.exp_stall = es;
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drives one decode slot just after a falling edge and lets the combinational outputs settle.
    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        de_valid     = v.de_valid;
        de_rs1       = v.rs1;
        de_uses_rs1  = v.uses1;
        de_rs2       = v.rs2;
        de_uses_rs2  = v.uses2;
        de_rd        = v.rd;
        de_reg_write = v.wr;
        de_is_load   = v.ld;
        flush        = v.fl;
        #1;
    endtask

    task automatic check_vector(input vec_t v, input int which, input int idx);
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] st;
        if (which == 1) begin
            a1 = 32'(bus1.rs1_sel);
            a2 = 32'(bus1.rs2_sel);
            st = 32'(bus1.stall);
        end else begin
            a1 = 32'(bus2.rs1_sel);
            a2 = 32'(bus2.rs2_sel);
            st = 32'(bus2.stall);
        end
        check_output($sformatf("dut%0d vec%0d stall", which, idx), st, 32'(v.exp_stall));
        if (!v.exp_stall) begin
            check_output($sformatf("dut%0d vec%0d rs1_sel", which, idx), a1, 32'(v.exp_rs1));
            check_output($sformatf("dut%0d vec%0d rs2_sel", which, idx), a2, 32'(v.exp_rs2));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        vec_t v;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        de_valid     = 1'b1;
        de_rs1       = 5'd5;
        de_uses_rs1  = 1'b1;
        de_rs2       = 5'd6;
        de_uses_rs2  = 1'b1;
        de_rd        = 5'd0;
        de_reg_write = 1'b0;
        de_is_load   = 1'b0;
        flush        = 1'b0;

        //  valid rs1 u1 rs2 u2 rd wr ld fl  e1 e2 es   (NUM_FWD_STAGES=2, LOAD_LAT=1)
        tbl1.push_back(mk(1, 1, 1, 2, 1,  5, 1, 0, 0, 0, 0, 0));
        tbl1.push_back(mk(1, 5, 1, 3, 1,  9, 1, 0, 0, 1, 0, 0));
        tbl1.push_back(mk(1, 5, 1, 9, 1, 10, 1, 0, 0, 2, 1, 0));
        tbl1.push_back(mk(1,10, 0,10, 1,  0, 1, 0, 0, 0, 1, 0));
        tbl1.push_back(mk(1, 0, 1,10, 1,  7, 1, 0, 0, 0, 2, 0));
        tbl1.push_back(mk(1, 1, 1, 2, 1,  7, 1, 0, 0, 0, 0, 0));
        tbl1.push_back(mk(1, 7, 1, 7, 1, 11, 0, 0, 0, 1, 1, 0));
        tbl1.push_back(mk(1, 1, 1, 0, 0,  6, 1, 1, 0, 0, 0, 0));
        tbl1.push_back(mk(1, 7, 1, 6, 1, 12, 1, 0, 0, 0, 0, 1));
        tbl1.push_back(mk(1, 7, 1, 6, 1, 12, 1, 0, 0, 0, 2, 0));
        tbl1.push_back(mk(1, 0, 0, 0, 0,  8, 1, 0, 1, 0, 0, 0));
        tbl1.push_back(mk(1, 8, 1,12, 1, 13, 0, 0, 0, 0, 2, 0));
        tbl1.push_back(mk(1, 0, 0, 0, 0, 14, 1, 1, 0, 0, 0, 0));
        tbl1.push_back(mk(1,14, 1, 0, 0, 13, 1, 0, 1, 1, 0, 0));
        tbl1.push_back(mk(1,14, 1, 0, 0, 15, 1, 1, 0, 2, 0, 0));
        tbl1.push_back(mk(0,15, 1, 0, 0, 16, 1, 0, 0, 1, 0, 0));
        tbl1.push_back(mk(1,15, 1,15, 1,  0, 0, 0, 0, 2, 2, 0));

        //  valid rs1 u1 rs2 u2 rd wr ld fl  e1 e2 es   (NUM_FWD_STAGES=4, LOAD_LAT=2)
        tbl2.push_back(mk(1, 1, 1, 2, 1,  5, 1, 0, 0, 0, 0, 0));
        tbl2.push_back(mk(1, 1, 1, 2, 1, 20, 1, 0, 0, 0, 0, 0));
        tbl2.push_back(mk(1, 1, 1, 2, 1, 21, 1, 0, 0, 0, 0, 0));
        tbl2.push_back(mk(1, 1, 1, 2, 1, 22, 1, 0, 0, 0, 0, 0));
        tbl2.push_back(mk(1, 5, 1, 0, 0,  0, 0, 0, 0, 4, 0, 0));
        tbl2.push_back(mk(1, 0, 0, 0, 0,  6, 1, 1, 0, 0, 0, 0));
        tbl2.push_back(mk(1, 6, 1, 0, 0, 23, 1, 0, 0, 0, 0, 1));
        tbl2.push_back(mk(1, 6, 1, 0, 0, 23, 1, 0, 0, 0, 0, 1));
        tbl2.push_back(mk(1, 6, 1, 0, 0, 23, 1, 0, 0, 3, 0, 0));
        tbl2.push_back(mk(1,23, 1, 6, 1,  0, 0, 0, 0, 1, 4, 0));

        #12;
        check_output("reset stall", 32'(bus1.stall), 32'd0);
        check_output("reset rs1_sel", 32'(bus1.rs1_sel), 32'd0);
        check_output("reset rs2_sel", 32'(bus1.rs2_sel), 32'd0);
        check_output("reset dut4 stall", 32'(bus2.stall), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check_output("reset stall_count", bus1.stall_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl1[i]) begin
            apply_stimulus(tbl1[i]);
            check_vector(tbl1[i], 1, i);
        end
`ifdef FWD_STALL_CNT_EN
        @(negedge clk);
        check_output("dut1 stall_count", bus1.stall_count, 32'd1);
`endif

        do_reset();
        foreach (tbl2[i]) begin
            apply_stimulus(tbl2[i]);
            check_vector(tbl2[i], 2, i);
        end
`ifdef FWD_STALL_CNT_EN
        @(negedge clk);
        check_output("dut4 stall_count", bus2.stall_count, 32'd2);
`endif

        // Reset arriving between edges in the middle of a load-use stall.
        do_reset();
        v = mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0);
        apply_stimulus(v);
        v = mk(1, 0, 0, 6, 1, 17, 1, 0, 0, 0, 0, 1);
        apply_stimulus(v);
        check_vector(v, 1, 100);
        reset = 1'b1;
        #1;
        check_output("async reset stall", 32'(bus1.stall), 32'd0);
        check_output("async reset rs2_sel", 32'(bus1.rs2_sel), 32'd0);
`ifdef FWD_STALL_CNT_EN
        check_output("async reset stall_count", bus1.stall_count, 32'd0);
`endif
        #1;
        reset = 1'b0;
        v = mk(1, 17, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(v);
        check_vector(v, 1, 101);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
